instr_loader: RTL

Upstream program-loading stage for the single-cycle CPU. It receives a byte stream over a valid/ready handshake and assembles each group of four bytes into a 32-bit instruction word, most significant byte first. Each word is written into the instruction memory at a sequential 8-bit address. A trailing XOR checksum byte is verified before `cpu_run` releases the CPU. The integration wires `~cpu_run` as the synchronous reset of the CPU's PC, so the PC starts at address 0 only after a good load.

---
 rtl/instr_loader_if.sv | 36 +++
 rtl/instr_loader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_if
// Purpose  : Byte-stream input, control and instruction-memory write bus
//            of the program loader.
// Revision : 1.0  initial release
// ============================================================================
interface instr_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] load_len;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              busy;
    logic              cpu_run;
    logic              err;

    // Host / stream source side
    modport master (
        output start, load_len, in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata, busy, cpu_run, err
    );

    // Loader side
    modport slave (
        input  start, load_len, in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata, busy, cpu_run, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Purpose  : Assembles a byte stream (MSB first) into instruction words,
//            writes them to sequential instruction-memory addresses and
//            verifies a trailing XOR checksum before releasing the CPU.
// Revision : 1.0  initial release
// ============================================================================
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input wire             clk,
    input wire             rst,
    instr_loader_if.slave  bus
);

    localparam int c_BPW  = DATA_W / 8;
    localparam int c_BC_W = (c_BPW > 1) ? $clog2(c_BPW) : 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_CHECK = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_ERR   = 3'd4;

    // load_len of zero selects the full 2^ADDR_W-word memory
    localparam logic [ADDR_W:0]   c_MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_ONE       = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [c_BC_W-1:0] c_LAST_BYTE = c_BC_W'(c_BPW - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_word_cnt;
    logic [c_BC_W-1:0] r_byte_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [7:0]        r_csum;
    logic [7:0]        w_csum_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_in_ready;
    logic              w_busy;
    logic              w_cpu_run;
    logic              w_err;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_last_byte;
    logic              w_last_word;

    assign w_accept    = bus.in_valid && w_in_ready;
    // start is only honoured while no load is in progress
    assign w_start_ok  = bus.start &&
                         ((r_state == c_IDLE) || (r_state == c_DONE) || (r_state == c_ERR));
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_last_word = (r_word_cnt == (r_len - c_ONE));
    assign w_csum_next = r_csum ^ bus.in_data;

    // Single-byte words need no shifting; wider words shift MSB first
    generate
        if (DATA_W == 8) begin : g_shift_byte
            assign w_shift_next = bus.in_data;
        end else begin : g_shift_wide
            assign w_shift_next = {r_shift[DATA_W-9:0], bus.in_data};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE, c_ERR: begin
                if (bus.start) begin
                    w_next = c_LOAD;
                end
            end
            c_LOAD: begin
                if (w_accept && w_last_byte && w_last_word) begin
                    w_next = c_CHECK;
                end
            end
            c_CHECK: begin
                if (w_accept) begin
                    w_next = (bus.in_data == r_csum) ? c_DONE : c_ERR;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_cpu_run  = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            c_LOAD, c_CHECK: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            c_DONE:  w_cpu_run = 1'b1;
            c_ERR:   w_err     = 1'b1;
            default: ;
        endcase
    end

    // Word assembly, checksum accumulation and the registered memory write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_csum     <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_len      <= (bus.load_len == '0) ? c_MAX_LEN : {1'b0, bus.load_len};
                r_word_cnt <= '0;
                r_byte_cnt <= '0;
                r_csum     <= '0;
            end else if (w_accept && (r_state == c_LOAD)) begin
                r_shift    <= w_shift_next;
                r_csum     <= w_csum_next;
                r_byte_cnt <= w_last_byte ? '0 : (r_byte_cnt + 1'b1);
                if (w_last_byte) begin
                    // Completed word is written the cycle after its last byte
                    r_we       <= 1'b1;
                    r_addr     <= r_word_cnt[ADDR_W-1:0];
                    r_wdata    <= w_shift_next;
                    r_word_cnt <= r_word_cnt + c_ONE;
                end
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_busy;
    assign bus.cpu_run  = w_cpu_run;
    assign bus.err      = w_err;
    assign bus.im_we    = r_we;
    assign bus.im_addr  = r_addr;
    assign bus.im_wdata = r_wdata;

endmodule
`default_nettype wire
